// File: rtl/e203_flush_pkg.sv
// rtl/e203_flush_pkg.sv - shared types for the EXU flush arbiter
package e203_flush_pkg;

    localparam int FL_PC_SIZE = 32;

    typedef enum logic [1:0] {
        FL_IDLE,
        FL_REQ,
        FL_DRAIN
    } fl_state_e;

    typedef struct packed {
        logic [FL_PC_SIZE-1:0] op1;
        logic [FL_PC_SIZE-1:0] op2;
        logic [FL_PC_SIZE-1:0] pc;
    } flush_tgt_t;

    localparam logic SRC_EXCP = 1'b1;

endpackage

// File: rtl/e203_flush_drain_cnt.sv
// rtl/e203_flush_drain_cnt.sv - loadable down-counter with zero flag
module e203_flush_drain_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/e203_exu_flush_arb.sv
// rtl/e203_exu_flush_arb.sv - EXCP/BRCH flush arbiter into the IFU flush port
module e203_exu_flush_arb
    import e203_flush_pkg::*;
#(
    parameter int PC_SIZE   = FL_PC_SIZE,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               excp_flush_req,
    input  logic [PC_SIZE-1:0] excp_flush_add_op1,
    input  logic [PC_SIZE-1:0] excp_flush_add_op2,
    input  logic [PC_SIZE-1:0] excp_flush_pc,
    output logic               excp_flush_ack,
    input  logic               brch_flush_req,
    input  logic [PC_SIZE-1:0] brch_flush_add_op1,
    input  logic [PC_SIZE-1:0] brch_flush_add_op2,
    input  logic [PC_SIZE-1:0] brch_flush_pc,
    output logic               brch_flush_ack,
    output logic               pipe_flush_req,
    output logic [PC_SIZE-1:0] pipe_flush_add_op1,
    output logic [PC_SIZE-1:0] pipe_flush_add_op2,
    output logic [PC_SIZE-1:0] pipe_flush_pc,
    input  logic               pipe_flush_ack,
    output logic               flush_src,
    output logic               flush_busy,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int DW           = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam int DRAIN_LOAD_I = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_LOAD_I);

    fl_state_e        state_q;
    fl_state_e        state_d;
    flush_tgt_t       tgt_q;
    logic             src_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cap_excp;
    logic             cap_brch;
    logic             accept;
    logic             drain_zero;

    // pipe_flush_ack only counts while a request is actually on the port
    assign accept = (state_q == FL_REQ) && pipe_flush_ack;

    e203_flush_drain_cnt #(
        .W (DW)
    ) u_drain_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && (DRAIN_CYC != 0)),
        .load_val (DRAIN_LOAD),
        .dec      (state_q == FL_DRAIN),
        .zero     (drain_zero)
    );

    always_comb begin
        state_d  = state_q;
        cap_excp = 1'b0;
        cap_brch = 1'b0;
        case (state_q)
            FL_IDLE: begin
                if (excp_flush_req) begin
                    cap_excp = 1'b1;
                    state_d  = FL_REQ;
                end else if (brch_flush_req) begin
                    cap_brch = 1'b1;
                    state_d  = FL_REQ;
                end
            end
            FL_REQ: begin
                // grant is locked here: no re-arbitration until the IFU acks
                if (pipe_flush_ack) begin
                    state_d = (DRAIN_CYC == 0) ? FL_IDLE : FL_DRAIN;
                end
            end
            FL_DRAIN: begin
                if (drain_zero) begin
                    state_d = FL_IDLE;
                end
            end
            default: state_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FL_IDLE;
            tgt_q   <= '0;
            src_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cap_excp) begin
                tgt_q.op1 <= excp_flush_add_op1;
                tgt_q.op2 <= excp_flush_add_op2;
                tgt_q.pc  <= excp_flush_pc;
                src_q     <= SRC_EXCP;
            end else if (cap_brch) begin
                tgt_q.op1 <= brch_flush_add_op1;
                tgt_q.op2 <= brch_flush_add_op2;
                tgt_q.pc  <= brch_flush_pc;
                src_q     <= ~SRC_EXCP;
            end
            if (accept && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign excp_flush_ack     = accept && (src_q == SRC_EXCP);
    assign brch_flush_ack     = accept && (src_q != SRC_EXCP);
    assign pipe_flush_req     = (state_q == FL_REQ);
    assign pipe_flush_add_op1 = tgt_q.op1;
    assign pipe_flush_add_op2 = tgt_q.op2;
    assign pipe_flush_pc      = tgt_q.pc;
    assign flush_src          = src_q;
    assign flush_busy         = (state_q != FL_IDLE);
    assign flush_cnt          = cnt_q;

endmodule
